// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath.
// Holds the neuron FSM states, post-fire reset modes and saturation.
package snn_pkg;

  typedef enum logic {
    ST_INTEG,
    ST_REFRACT
  } state_t;

  localparam int RST_ZERO = 0;
  localparam int RST_SUB  = 1;

  // Symmetric clamp: the most-negative code of the target width is never produced.
  function automatic int sat_add(
    input int a,
    input int b,
    input int width
  );
    int lim;
    int s;
    lim = (1 << (width - 1)) - 1;
    s   = a + b;
    if (s > lim)  return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/lif_synapse_sum.sv
// Combinational signed weighted sum over N pos/neg spike channels.
// Output is wide enough that no channel pattern can overflow it.
module lif_synapse_sum
  import snn_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int SUM_W    = WEIGHT_W + 1 + $clog2(N)
) (
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic [N-1:0]          pos_in,
  input  logic [N-1:0]          neg_in,
  output logic signed [SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (pos_in[i] && !neg_in[i])
        sum = sum + SUM_W'($signed(weight[i*WEIGHT_W +: WEIGHT_W]));
      else if (neg_in[i] && !pos_in[i])
        sum = sum - SUM_W'($signed(weight[i*WEIGHT_W +: WEIGHT_W]));
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron with N weighted synaptic channels.
// Saturating membrane, periodic leak, refractory hold and ternary spikes.
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int N           = 4,
  parameter int WEIGHT_W    = 4,
  parameter int POT_W       = 8,
  parameter int THRESH_W    = 4,
  parameter int LEAK        = 1,
  parameter int LEAK_PERIOD = 8,
  parameter int REFRACT_CYC = 2,
  parameter int RESET_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N*WEIGHT_W-1:0]   weight,
  input  logic [THRESH_W-1:0]     threshold,
  input  logic [N-1:0]            pos_in,
  input  logic [N-1:0]            neg_in,
  output logic                    pos_out,
  output logic                    neg_out,
  output logic signed [POT_W-1:0] potential,
  output logic                    refractory
);

  localparam int SUM_W = WEIGHT_W + 1 + $clog2(N);
  localparam int LCW   = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RCL   = $clog2(REFRACT_CYC + 1);
  localparam int RCW   = (RCL < 1) ? 1 : RCL;

  state_t                  state, state_n;
  logic [LCW-1:0]          lcnt, lcnt_n;
  logic [RCW-1:0]          rcnt, rcnt_n;
  logic signed [POT_W-1:0] pot, pot_nx;
  logic                    pos_q, neg_q, pos_n, neg_n;
  logic signed [SUM_W-1:0] sum;
  logic                    tick;
  int                      pot_i, pot_l, pot_s, thr_i, mag;

  lif_synapse_sum #(
    .N        (N),
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W)
  ) u_sum (
    .weight (weight),
    .pos_in (pos_in),
    .neg_in (neg_in),
    .sum    (sum)
  );

  always_comb begin
    state_n = state;
    lcnt_n  = lcnt;
    rcnt_n  = rcnt;
    pot_nx  = pot;
    pos_n   = 1'b0;
    neg_n   = 1'b0;
    pot_i   = int'(pot);
    thr_i   = int'(threshold);
    tick    = (LEAK_PERIOD != 0) && (int'(lcnt) == LEAK_PERIOD - 1);
    mag     = (pot_i < 0) ? -pot_i : pot_i;
    if (mag > LEAK) mag = LEAK;
    // Leak pulls toward zero but never past it.
    pot_l   = pot_i;
    if (tick) pot_l = (pot_i < 0) ? pot_i + mag : pot_i - mag;
    pot_s   = sat_add(pot_l, int'(sum), POT_W);
    if (en) begin
      if (LEAK_PERIOD != 0) lcnt_n = tick ? '0 : lcnt + 1'b1;
      unique case (state)
        ST_INTEG: begin
          pot_nx = POT_W'(pot_s);
          if (threshold != '0 && pot_s >= thr_i) begin
            pos_n  = 1'b1;
            pot_nx = (RESET_MODE == RST_ZERO) ? '0 : POT_W'(pot_s - thr_i);
          end else if (threshold != '0 && pot_s <= -thr_i) begin
            neg_n  = 1'b1;
            pot_nx = (RESET_MODE == RST_ZERO) ? '0 : POT_W'(pot_s + thr_i);
          end
          if ((pos_n || neg_n) && REFRACT_CYC > 0) begin
            state_n = ST_REFRACT;
            rcnt_n  = RCW'(REFRACT_CYC);
          end
        end
        ST_REFRACT: begin
          if (rcnt == RCW'(1)) state_n = ST_INTEG;
          else rcnt_n = rcnt - 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INTEG;
      lcnt  <= '0;
      rcnt  <= '0;
      pot   <= '0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state <= state_n;
      lcnt  <= lcnt_n;
      rcnt  <= rcnt_n;
      pot   <= pot_nx;
      pos_q <= pos_n;
      neg_q <= neg_n;
    end
  end

  assign pos_out    = pos_q;
  assign neg_out    = neg_q;
  assign potential  = pot;
  assign refractory = (state == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: directed scenarios plus random traffic,
// two parameterisations checked against a behavioural neuron model.
module tb_lif_neuron_array;

  logic              clk = 1'b0;
  logic              rst, en;
  logic [15:0]       weight;
  logic [3:0]        threshold, pos_in, neg_in;
  logic              pos_a, neg_a, refr_a, pos_b, neg_b, refr_b;
  logic signed [7:0] pot_a, pot_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pot;
    int lc;
    int rc;
    bit refr;
    bit po;
    bit no;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  lif_neuron_array dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .weight     (weight),
    .threshold  (threshold),
    .pos_in     (pos_in),
    .neg_in     (neg_in),
    .pos_out    (pos_a),
    .neg_out    (neg_a),
    .potential  (pot_a),
    .refractory (refr_a)
  );

  lif_neuron_array #(
    .LEAK_PERIOD (0),
    .REFRACT_CYC (0),
    .RESET_MODE  (1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .weight     (weight),
    .threshold  (threshold),
    .pos_in     (pos_in),
    .neg_in     (neg_in),
    .pos_out    (pos_b),
    .neg_out    (neg_b),
    .potential  (pot_b),
    .refractory (refr_b)
  );

  function automatic mdl_t mstep(
    input mdl_t       m,
    input int         lp,
    input int         rcyc,
    input int         mode,
    input bit         e,
    input logic [15:0] w,
    input int         thr,
    input logic [3:0] p,
    input logic [3:0] ng
  );
    int sum, wi, pl, pn, lk;
    bit tick;
    m.po = 0;
    m.no = 0;
    if (!e) return m;
    tick = (lp != 0) && (m.lc == lp - 1);
    if (lp != 0) m.lc = (m.lc + 1) % lp;
    if (m.refr) begin
      m.rc--;
      if (m.rc == 0) m.refr = 0;
      return m;
    end
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      wi = int'(w[i*4 +: 4]);
      if (wi > 7) wi -= 16;
      if (p[i] && !ng[i]) sum += wi;
      else if (ng[i] && !p[i]) sum -= wi;
    end
    pl = m.pot;
    if (tick) begin
      lk = (pl < 0) ? -pl : pl;
      if (lk > 1) lk = 1;
      pl = (pl < 0) ? pl + lk : pl - lk;
    end
    pn = pl + sum;
    if (pn > 127) pn = 127;
    if (pn < -127) pn = -127;
    if (thr != 0 && pn >= thr) begin
      m.po = 1;
      m.pot = mode ? pn - thr : 0;
    end else if (thr != 0 && pn <= -thr) begin
      m.no = 1;
      m.pot = mode ? pn + thr : 0;
    end else begin
      m.pot = pn;
    end
    if ((m.po || m.no) && rcyc > 0) begin
      m.refr = 1;
      m.rc = rcyc;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_pot", pot_a, ma.pot);
    chk("a_pos", pos_a, int'(ma.po));
    chk("a_neg", neg_a, int'(ma.no));
    chk("a_refr", refr_a, int'(ma.refr));
    chk("b_pot", pot_b, mb.pot);
    chk("b_pos", pos_b, int'(mb.po));
    chk("b_neg", neg_b, int'(mb.no));
    chk("b_refr", refr_b, int'(mb.refr));
  endtask

  task automatic reset_all();
    rst = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input bit e, input logic [3:0] p, input logic [3:0] ng);
    en = e;
    pos_in = p;
    neg_in = ng;
    @(posedge clk);
    ma = mstep(ma, 8, 2, 0, e, weight, int'(threshold), p, ng);
    mb = mstep(mb, 0, 0, 1, e, weight, int'(threshold), p, ng);
    #1;
    compare_all();
  endtask

  initial begin
    int sat_exp [10] = '{28, 56, 84, 112, 127, 127, 127, 127, 127, 127};
    rst = 1'b1;
    en = 1'b0;
    weight = '0;
    threshold = '0;
    pos_in = '0;
    neg_in = '0;
    #2;
    reset_all();

    weight = 16'h0001;
    threshold = 4'd2;
    step(1, 4'h1, 4'h0); chk("legacy_p1", pot_b, 1);
    step(1, 4'h0, 4'h1); chk("legacy_p2", pot_b, 0);
    step(1, 4'h1, 4'h0); chk("legacy_p3", pot_b, 1);
    chk("legacy_nofire", pos_b, 0);
    step(1, 4'h1, 4'h0); chk("legacy_p4", pot_b, 0);
    chk("legacy_fire", pos_b, 1);
    step(1, 4'h0, 4'h0); chk("legacy_onecyc", pos_b, 0);

    reset_all();
    weight = 16'h3E51;
    threshold = 4'd6;
    step(1, 4'hF, 4'h0);
    chk("multi_pos", pos_a, 1);
    chk("multi_pot_zero", pot_a, 0);
    chk("multi_pot_sub", pot_b, 1);

    reset_all();
    weight = 16'h0050;
    threshold = 4'd8;
    step(1, 4'h0, 4'h2); chk("inh_pot1", pot_a, -5);
    step(1, 4'h0, 4'h2); chk("inh_neg", neg_a, 1);
    chk("inh_pot0", pot_a, 0);
    chk("inh_refr1", refr_a, 1);
    step(1, 4'h0, 4'h2); chk("inh_refr2", refr_a, 1);
    chk("inh_hold", pot_a, 0);
    step(1, 4'h0, 4'h2); chk("inh_refr_end", refr_a, 0);
    chk("inh_ignored", pot_a, 0);
    step(1, 4'h0, 4'h2); chk("inh_resume", pot_a, -5);

    reset_all();
    step(1, 4'h0, 4'h2);
    step(1, 4'h0, 4'h2);
    chk("mid_refr", refr_a, 1);
    reset_all();

    weight = 16'h7777;
    threshold = 4'd0;
    for (int k = 0; k < 10; k++) begin
      step(1, 4'hF, 4'h0);
      chk("sat_pot", pot_a, sat_exp[k]);
      chk("sat_nospike", pos_a, 0);
    end

    reset_all();
    weight = 16'h0003;
    step(1, 4'h1, 4'h0); chk("leak_pre", pot_a, 3);
    weight = 16'h0000;
    repeat (7) step(1, 4'h0, 4'h0); chk("leak_t1", pot_a, 2);
    repeat (8) step(1, 4'h0, 4'h0); chk("leak_t2", pot_a, 1);
    repeat (8) step(1, 4'h0, 4'h0); chk("leak_t3", pot_a, 0);
    repeat (8) step(1, 4'h0, 4'h0); chk("leak_t4", pot_a, 0);

    reset_all();
    weight = 16'h0003;
    step(1, 4'h0, 4'h1); chk("nleak_pre", pot_a, -3);
    weight = 16'h0000;
    repeat (7) step(1, 4'h0, 4'h0); chk("nleak_t1", pot_a, -2);
    repeat (8) step(1, 4'h0, 4'h0); chk("nleak_t2", pot_a, -1);
    repeat (8) step(1, 4'h0, 4'h0); chk("nleak_t3", pot_a, 0);

    reset_all();
    weight = 16'h0001;
    step(1, 4'h1, 4'h0);
    repeat (20) step(0, 4'h1, 4'h0);
    chk("en_hold", pot_a, 1);
    repeat (6) step(1, 4'h0, 4'h0);
    chk("en_stall", pot_a, 1);
    step(1, 4'h0, 4'h0);
    chk("en_tick", pot_a, 0);

    reset_all();
    repeat (400) begin
      weight = 16'($urandom);
      threshold = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) reset_all();
      step($urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
